// File: rtl/pwm_dac_pkg.sv
// Shared definitions for the multi-channel PWM / sigma-delta DAC.
package pwm_dac_pkg;

  localparam int   DEF_WIDTH = 8;
  localparam int   FRAME_LEN = 1 << DEF_WIDTH;
  localparam logic MODE_PWM  = 1'b0;
  localparam logic MODE_SD   = 1'b1;

  // Signed two's-complement to offset binary: flip the sign bit of a w-bit value.
  function automatic logic [31:0] to_offset_bin(input logic [31:0] s, input int w);
    return s ^ (32'd1 << (w - 1));
  endfunction

endpackage

// File: rtl/pwm_dac_chan.sv
// One DAC channel: active duty register plus PWM comparator / first-order sigma-delta modulator.
module pwm_dac_chan
  import pwm_dac_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] cnt,
  input  logic             mode_q,
  input  logic             load,
  input  logic             clr,
  input  logic [WIDTH-1:0] duty,
  output logic             pwm
);

  logic [WIDTH-1:0] duty_q, duty_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic             pwm_q, pwm_d;
  logic [WIDTH:0]   sum;

  always_comb begin
    sum    = {1'b0, acc_q} + {1'b0, duty_q};
    duty_d = load ? duty : duty_q;
    acc_d  = acc_q;
    pwm_d  = 1'b0;
    if (mode_q == MODE_SD) begin
      acc_d = sum[WIDTH-1:0];
      pwm_d = sum[WIDTH];
    end else begin
      pwm_d = (cnt < duty_q);
    end
    // A mode change restarts the modulator from a known phase.
    if (clr) acc_d = '0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      duty_q <= {1'b1, {(WIDTH-1){1'b0}}};
      acc_q  <= '0;
      pwm_q  <= 1'b0;
    end else begin
      duty_q <= duty_d;
      acc_q  <= acc_d;
      pwm_q  <= pwm_d;
    end
  end

  assign pwm = pwm_q;

endmodule

// File: rtl/pwm_dac_mc.sv
// Multi-channel PWM DAC top: frame counter, double-buffered sample handshake, mode latch.
module pwm_dac_mc
  import pwm_dac_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 2
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [CHANNELS*WIDTH-1:0] s_data,
  input  logic                      s_valid,
  output logic                      s_ready,
  input  logic                      mode,
  output logic [CHANNELS-1:0]       pwm,
  output logic                      frame_start,
  output logic                      underrun
);

  logic [WIDTH-1:0]          cnt_q, cnt_d;
  logic [CHANNELS*WIDTH-1:0] shadow_q, shadow_d;
  logic                      full_q, full_d;
  logic                      mode_q, mode_d;
  logic                      fs_q, fs_d;
  logic                      ur_q, ur_d;
  logic                      boundary, xfer, load, clr;

  assign boundary = (cnt_q == {WIDTH{1'b1}});
  assign s_ready  = !full_q || boundary;
  assign xfer     = s_valid && s_ready;
  assign load     = boundary && full_q;
  assign clr      = boundary && (mode != mode_q);

  always_comb begin
    cnt_d    = cnt_q + 1'b1;
    shadow_d = xfer ? s_data : shadow_q;
    // A boundary transfer refills the shadow in the same edge it drains.
    full_d   = xfer ? 1'b1 : (load ? 1'b0 : full_q);
    mode_d   = boundary ? mode : mode_q;
    fs_d     = boundary;
    ur_d     = boundary && !full_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q    <= '0;
      shadow_q <= '0;
      full_q   <= 1'b0;
      mode_q   <= MODE_PWM;
      fs_q     <= 1'b0;
      ur_q     <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      shadow_q <= shadow_d;
      full_q   <= full_d;
      mode_q   <= mode_d;
      fs_q     <= fs_d;
      ur_q     <= ur_d;
    end
  end

  assign frame_start = fs_q;
  assign underrun    = ur_q;

  for (genvar k = 0; k < CHANNELS; k++) begin : g_chan
    logic [WIDTH-1:0] duty;
    assign duty = WIDTH'(to_offset_bin(32'(shadow_q[k*WIDTH +: WIDTH]), WIDTH));

    pwm_dac_chan #(.WIDTH(WIDTH)) u_chan (
      .clk    (clk),
      .rst_n  (rst_n),
      .cnt    (cnt_q),
      .mode_q (mode_q),
      .load   (load),
      .clr    (clr),
      .duty   (duty),
      .pwm    (pwm[k])
    );
  end

endmodule
